// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and helpers for the programmable clock divider.
//   state_e    - controller sequencing states (idle / running / stopping)
//   DIV_MIN    - smallest legal divide ratio
//   ceil_half  - high-phase length in clk cycles for a ratio N
package clk_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStop
  } state_e;

  localparam int unsigned DIV_MIN = 2;

  function automatic int unsigned ceil_half(input int unsigned n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: ratio-update handshake between config logic and the divider controller.
//   cfg_valid  - new ratio offered (master -> slave)
//   cfg_div    - requested ratio N (master -> slave)
//   cfg_ready  - controller can accept a ratio (slave -> master)
//   cfg_err    - one-cycle pulse: last accepted ratio was illegal (slave -> master)
// DIV_W must match the DIV_W of the controller it is bound to.
interface clk_div_ctrl_if #(
  parameter int unsigned DIV_W = 8
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/clk_div_core.sv
// clk_div_core: period counter and divided-clock shaping.
//   clk, rst  - system clock, asynchronous active-low reset
//   run       - controller is in RUN or STOP; counter advances
//   start     - leaving IDLE this edge: restart period with output high
//   halt      - final wrap of STOP: return to idle with output low
//   div       - ratio currently in effect (>= 2)
//   wrap      - last cycle of the current period
//   div_out   - divided clock
// Build option CLK_DIV_ODD50_EN: for odd ratios the high phase is floor(N/2) cycles
// plus half a cycle from a negedge flop, giving an exact 50% duty. Undefined, the
// output is posedge-only with ceil(N/2) high cycles.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             start,
  input  logic             halt,
  input  logic [DIV_W-1:0] div,
  output logic             wrap,
  output logic             div_out
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] high_len;
  logic             div_q, div_d;

  // Counter never exceeds div-1, so the compare cannot overflow DIV_W bits.
  assign wrap = run && (cnt_q == (div - DIV_W'(1)));

`ifdef CLK_DIV_ODD50_EN
  // Odd ratios: shorten the posedge high phase by one cycle; the negedge flop
  // adds back half a cycle on the falling edge.
  always_comb begin
    high_len = DIV_W'(ceil_half(32'(div)));
    if (div[0]) begin
      high_len = div >> 1;
    end
  end
`else
  always_comb begin
    high_len = DIV_W'(ceil_half(32'(div)));
  end
`endif

  always_comb begin
    cnt_d = '0;
    div_d = 1'b0;
    if (start) begin
      cnt_d = '0;
      div_d = 1'b1;
    end else if (halt) begin
      cnt_d = '0;
      div_d = 1'b0;
    end else if (run) begin
      cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
      // Set on entering count 0, clear on entering count high_len, else hold.
      if (cnt_d == '0) begin
        div_d = 1'b1;
      end else if (cnt_d == high_len) begin
        div_d = 1'b0;
      end else begin
        div_d = div_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

`ifdef CLK_DIV_ODD50_EN
  logic div_neg_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      div_neg_q <= 1'b0;
    end else begin
      div_neg_q <= div_q;
    end
  end

  // Rising edge still comes from the posedge flop; only the fall is stretched.
  assign div_out = div_q | (div[0] & div_neg_q);
`else
  assign div_out = div_q;
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for a programmable integer clock divider.
// Accepts ratio updates over a valid/ready handshake, sequences start/stop and
// switches ratios only on period boundaries so div_out never glitches.
//   clk, rst     - system clock, asynchronous active-low reset
//   en           - run request (level)
//   cfg          - ratio handshake (slave side): cfg_valid/cfg_div in, cfg_ready/cfg_err out
//   div_out      - divided clock
//   period_done  - high in the last clk cycle of each output period
//   cur_div      - ratio currently in effect
//   busy         - high in RUN or STOP
// Build option CLK_DIV_ODD50_EN (see clk_div_core): exact 50% duty for odd ratios.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  clk_div_ctrl_if.slave    cfg,
  output logic             div_out,
  output logic             period_done,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic             err_q, err_d;

  logic             wrap;
  logic             run;
  logic             start;
  logic             halt;
  logic             xfer;
  logic             legal;

  assign xfer  = cfg.cfg_valid && !pend_q;
  assign legal = cfg.cfg_div >= DIV_W'(DIV_MIN);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StRun;
      end
      StRun: begin
        if (!en) state_d = StStop;
      end
      StStop: begin
        // A renewed request resumes without disturbing the running period.
        if (en) begin
          state_d = StRun;
        end else if (wrap) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    run   = (state_q != StIdle);
    start = (state_q == StIdle) && en;
    halt  = (state_q == StStop) && !en && wrap;
    busy  = run;
  end

  // ---------------------------------------------------------------------------
  // Ratio handshake, pending register, error pulse
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    cur_div_d  = cur_div_q;
    err_d      = xfer && !legal;

    // A pending ratio is applied at the next wrap. One accepted on the final
    // STOP wrap has no further wrap to wait for, so IDLE applies it directly.
    if (pend_q && (wrap || (state_q == StIdle))) begin
      cur_div_d = pend_div_q;
      pend_d    = 1'b0;
    end

    // xfer implies !pend_q, so this never collides with the apply above.
    if (xfer && legal) begin
      if (state_q == StIdle) begin
        cur_div_d = cfg.cfg_div;
      end else begin
        pend_d     = 1'b1;
        pend_div_d = cfg.cfg_div;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      cur_div_q  <= DIV_W'(DEFAULT_DIV);
      err_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      cur_div_q  <= cur_div_d;
      err_q      <= err_d;
    end
  end

  assign cfg.cfg_ready = !pend_q;
  assign cfg.cfg_err   = err_q;
  assign cur_div       = cur_div_q;
  assign period_done   = wrap;

  // ---------------------------------------------------------------------------
  // Counter and output shaping
  // ---------------------------------------------------------------------------
  clk_div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .start   (start),
    .halt    (halt),
    .div     (cur_div_q),
    .wrap    (wrap),
    .div_out (div_out)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: randomized scoreboard bench for clk_div_ctrl (default build).
// A behavioural model tracks the position inside the current output period and
// pushes the expected outputs each cycle plus the expected ratio of every period
// it starts; a negedge monitor pops and compares, and also measures each period's
// length and high time directly from div_out.
module tb_clk_div_ctrl;

  localparam int unsigned DIV_W       = 8;
  localparam int unsigned DEFAULT_DIV = 5;
  localparam int          NCYC        = 3000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en  = 1'b0;
  logic             div_out;
  logic             period_done;
  logic [DIV_W-1:0] cur_div;
  logic             busy;

  clk_div_ctrl_if #(.DIV_W(DIV_W)) cfg_if ();

  clk_div_ctrl #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg         (cfg_if),
    .div_out     (div_out),
    .period_done (period_done),
    .cur_div     (cur_div),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             div_out;
    logic             period_done;
    logic [DIV_W-1:0] cur_div;
    logic             busy;
    logic             cfg_ready;
    logic             cfg_err;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned per_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          mon_on = 1'b0;

  // Reference model: "active" = producing periods, "stopping" = stop requested,
  // pos = cycle index inside the current period, n = ratio in effect.
  bit          m_active, m_stopping, m_pend, m_err;
  int unsigned m_pos, m_n, m_pend_n;

  function automatic void check(input string name, input longint unsigned got,
                                input longint unsigned want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, want);
    end
  endfunction

  function automatic void model_reset();
    m_active   = 1'b0;
    m_stopping = 1'b0;
    m_pend     = 1'b0;
    m_err      = 1'b0;
    m_pos      = 0;
    m_n        = DEFAULT_DIV;
    m_pend_n   = 0;
    per_q.delete();
  endfunction

  function automatic void model_step(input bit en_s, input bit valid_s, input int unsigned div_s);
    bit was_active, boundary, xfer, new_period;
    was_active = m_active;
    boundary   = m_active && (m_pos == m_n - 1);
    xfer       = valid_s && !m_pend;
    m_err      = xfer && (div_s < 2);
    // A ratio accepted while running waits for the first period boundary after it.
    if (m_pend && (boundary || !m_active)) begin
      m_n    = m_pend_n;
      m_pend = 1'b0;
    end
    if (xfer && div_s >= 2) begin
      if (m_active) begin
        m_pend   = 1'b1;
        m_pend_n = div_s;
      end else begin
        m_n = div_s;
      end
    end
    new_period = 1'b0;
    if (!was_active) begin
      if (en_s) begin
        m_active   = 1'b1;
        m_stopping = 1'b0;
        m_pos      = 0;
        new_period = 1'b1;
      end
    end else begin
      m_pos = boundary ? 0 : m_pos + 1;
      if (en_s) begin
        m_stopping = 1'b0;
      end else if (m_stopping && boundary) begin
        m_active = 1'b0;
        m_pos    = 0;
      end else begin
        m_stopping = 1'b1;
      end
      new_period = m_active && boundary;
    end
    if (new_period) per_q.push_back(m_n);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.div_out     = m_active && (m_pos < (m_n + 1) / 2);
    e.period_done = m_active && (m_pos == m_n - 1);
    e.cur_div     = DIV_W'(m_n);
    e.busy        = m_active;
    e.cfg_ready   = !m_pend;
    e.cfg_err     = m_err;
    return e;
  endfunction

  task automatic drive(input int c);
    if (c == 0) begin
      rst = 1'b1;
    end else if (c == 1500 || $urandom_range(0, 399) == 0) begin
      rst = 1'b0;
    end else begin
      rst = 1'b1;
    end
    if (c < 60) begin
      // Default ratio, free running.
      en               = 1'b1;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_div   = '0;
    end else begin
      if (c >= 120) begin
        if (en && $urandom_range(0, 24) == 0) begin
          en = 1'b0;
        end else if (!en && $urandom_range(0, 5) == 0) begin
          en = 1'b1;
        end
      end
      cfg_if.cfg_valid = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) begin
        cfg_if.cfg_div = DIV_W'($urandom_range(0, 40));
      end else begin
        cfg_if.cfg_div = DIV_W'($urandom_range(0, 9));
      end
    end
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      if (!rst) begin
        model_reset();
      end else begin
        model_step(en, cfg_if.cfg_valid, 32'(cfg_if.cfg_div));
      end
      #1;
      drive(c);
      // Reset is asynchronous: outputs must show reset values before the next edge.
      if (!rst) model_reset();
      exp_q.push_back(model_out());
      mon_on = 1'b1;
    end
    @(posedge clk);
    #1;
    mon_on = 1'b0;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  int unsigned p_len  = 0;
  int unsigned p_high = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow t=%0t got=empty expected=entry", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("div_out", div_out, e.div_out);
        check("period_done", period_done, e.period_done);
        check("cur_div", cur_div, e.cur_div);
        check("busy", busy, e.busy);
        check("cfg_ready", cfg_if.cfg_ready, e.cfg_ready);
        check("cfg_err", cfg_if.cfg_err, e.cfg_err);
      end
      // Whole-period view: length N, high for ceil(N/2) cycles.
      if (!rst || !busy) begin
        p_len  = 0;
        p_high = 0;
      end else begin
        p_len++;
        if (div_out) p_high++;
        if (period_done) begin
          if (per_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL period_unexpected t=%0t got=period_done expected=none", $time);
          end else begin
            int unsigned n;
            n = per_q.pop_front();
            check("period_len", p_len, n);
            check("period_high", p_high, (n + 1) / 2);
          end
          p_len  = 0;
          p_high = 0;
        end
      end
    end
  end

endmodule
